// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline command type and register-index width.
package cpu_types_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {PIPE_ENABLE, PIPE_STALL, PIPE_NOP} pipe_state_t;
endpackage

// File: rtl/pipeline_stage_controller_if.sv
// pipeline_stage_controller_if: hazard inputs and stage commands of the pipeline controller.
interface pipeline_stage_controller_if;
  import cpu_types_pkg::*;
  logic ihit, dhit, dmem_req_mem, branch_taken_mem, halt_mem, MemToReg_ex, RegWrite_ex;
  logic [REG_W-1:0] regWSEL_ex, rs_id, rt_id;
  logic pc_en, halted, dwait;
  pipe_state_t fd_state, de_state, em_state, mw_state;
  logic [31:0] stall_cycles, flush_count;
  modport master(
    output ihit, dhit, dmem_req_mem, branch_taken_mem, halt_mem, MemToReg_ex, RegWrite_ex,
    output regWSEL_ex, rs_id, rt_id,
    input pc_en, halted, dwait, fd_state, de_state, em_state, mw_state, stall_cycles, flush_count
  );
  modport slave(
    input ihit, dhit, dmem_req_mem, branch_taken_mem, halt_mem, MemToReg_ex, RegWrite_ex,
    input regWSEL_ex, rs_id, rt_id,
    output pc_en, halted, dwait, fd_state, de_state, em_state, mw_state, stall_cycles, flush_count
  );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an EX-stage load whose destination feeds an ID-stage source.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic             mem_to_reg,
  input  logic             reg_write,
  input  logic [REG_W-1:0] wsel,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             lu
);
  assign lu = mem_to_reg & reg_write & (wsel != '0) & ((wsel == rs) | (wsel == rt));
endmodule

// File: rtl/pipeline_stage_controller.sv
// pipeline_stage_controller: hazard FSM driving PC enable and per-register stage commands.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_stage_controller
  import cpu_types_pkg::*;
(
  input logic CLK,
  input logic RST,
  pipeline_stage_controller_if.slave bus
);
  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;
  state_t state, nxt;
  logic lu, dstall, live;
  load_use_detect u_lu (
    .mem_to_reg(bus.MemToReg_ex),
    .reg_write (bus.RegWrite_ex),
    .wsel      (bus.regWSEL_ex),
    .rs        (bus.rs_id),
    .rt        (bus.rt_id),
    .lu        (lu)
  );
  assign dstall = bus.dmem_req_mem & ~bus.dhit;
  assign live = (state == RUN) | (state == DWAIT);
  always_ff @(posedge CLK) state <= RST ? RUN : nxt;
  always_comb begin
    nxt = state;
    bus.pc_en = 1'b0;
    bus.fd_state = PIPE_NOP;
    bus.de_state = PIPE_NOP;
    bus.em_state = PIPE_NOP;
    bus.mw_state = PIPE_NOP;
    if (RST) nxt = RUN;
    else if (state == HALTED) begin
      bus.fd_state = PIPE_STALL;
      bus.de_state = PIPE_STALL;
      bus.em_state = PIPE_STALL;
      bus.mw_state = PIPE_STALL;
    end else if (state == DRAIN) begin
      bus.mw_state = PIPE_ENABLE;
      nxt = HALTED;
    end else if (dstall) begin
      bus.fd_state = PIPE_STALL;
      bus.de_state = PIPE_STALL;
      bus.em_state = PIPE_STALL;
      nxt = DWAIT;
    end else if (bus.halt_mem) begin
      bus.mw_state = PIPE_ENABLE;
      nxt = DRAIN;
    end else if (bus.branch_taken_mem) begin
      bus.pc_en = 1'b1;
      bus.mw_state = PIPE_ENABLE;
      nxt = RUN;
    end else if (lu) begin
      bus.fd_state = PIPE_STALL;
      bus.em_state = PIPE_ENABLE;
      bus.mw_state = PIPE_ENABLE;
      nxt = RUN;
    end else begin
      bus.pc_en = bus.ihit;
      bus.fd_state = bus.ihit ? PIPE_ENABLE : PIPE_NOP;
      bus.de_state = PIPE_ENABLE;
      bus.em_state = PIPE_ENABLE;
      bus.mw_state = PIPE_ENABLE;
      nxt = RUN;
    end
  end
  // dwait marks every cycle spent waiting on data memory, including the first one
  assign bus.dwait = ~RST & live & dstall;
  assign bus.halted = ~RST & (state == HALTED);
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (~bus.pc_en && state != HALTED && stall_q != '1) stall_q <= stall_q + 32'd1;
      // only the redirect path enables the PC while flushing the front end
      if (bus.pc_en && bus.fd_state == PIPE_NOP && flush_q != '1) flush_q <= flush_q + 32'd1;
    end
  end
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_stage_controller.sv
// tb_pipeline_stage_controller: directed vectors with a per-cycle expectation queue.
module tb_pipeline_stage_controller;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  pipeline_stage_controller_if bus();
  pipeline_stage_controller dut (.CLK(CLK), .RST(RST), .bus(bus));
  typedef struct {
    string tag;
    logic rst, pc, h, dw;
    pipe_state_t fd, de, em, mw;
    logic [31:0] sc, fc;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_fc = '0;
  function automatic pipe_state_t cmd(input byte c);
    return c == "S" ? PIPE_STALL : c == "N" ? PIPE_NOP : PIPE_ENABLE;
  endfunction
  task automatic cyc(input string tag, input logic rst, ih, dh, dr, br, hl, m2r, rw,
                     input logic [4:0] ws, rs, rt, input logic pc, input string c, input logic h, dw);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst;
    bus.ihit = ih;
    bus.dhit = dh;
    bus.dmem_req_mem = dr;
    bus.branch_taken_mem = br;
    bus.halt_mem = hl;
    bus.MemToReg_ex = m2r;
    bus.RegWrite_ex = rw;
    bus.regWSEL_ex = ws;
    bus.rs_id = rs;
    bus.rt_id = rt;
    e.tag = tag;
    e.rst = rst;
    e.pc = pc;
    e.h = h;
    e.dw = dw;
    e.fd = cmd(c[0]);
    e.de = cmd(c[1]);
    e.em = cmd(c[2]);
    e.mw = cmd(c[3]);
    e.sc = m_sc;
    e.fc = m_fc;
    q.push_back(e);
`ifdef PIPE_PERF_CNT_EN
    if (rst) begin
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (!pc && !h) m_sc = m_sc + 32'd1;
      if (pc && c == "NNNE") m_fc = m_fc + 32'd1;
    end
`endif
  endtask
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (bus.pc_en !== e.pc || bus.fd_state !== e.fd || bus.de_state !== e.de ||
          bus.em_state !== e.em || bus.mw_state !== e.mw || bus.halted !== e.h ||
          bus.dwait !== e.dw || (!e.rst && (bus.stall_cycles !== e.sc || bus.flush_count !== e.fc))) begin
        fails++;
        $display("FAIL %s: got pc_en=%b fd=%s de=%s em=%s mw=%s halted=%b dwait=%b stall=%0d flush=%0d; want pc_en=%b fd=%s de=%s em=%s mw=%s halted=%b dwait=%b stall=%0d flush=%0d",
                 e.tag, bus.pc_en, bus.fd_state.name(), bus.de_state.name(), bus.em_state.name(),
                 bus.mw_state.name(), bus.halted, bus.dwait, bus.stall_cycles, bus.flush_count,
                 e.pc, e.fd.name(), e.de.name(), e.em.name(), e.mw.name(), e.h, e.dw, e.sc, e.fc);
      end
    end
  end
  initial begin
    bus.ihit = 1'b1;
    bus.dhit = 1'b0;
    bus.dmem_req_mem = 1'b0;
    bus.branch_taken_mem = 1'b0;
    bus.halt_mem = 1'b0;
    bus.MemToReg_ex = 1'b0;
    bus.RegWrite_ex = 1'b0;
    bus.regWSEL_ex = '0;
    bus.rs_id = '0;
    bus.rt_id = '0;
    //   tag           rst ih dh dr br hl m2r rw ws rs rt  pc cmd     h  dw
    cyc("reset",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "NNNN", 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("run",       0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "EEEE", 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("dstall",    0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "SSSN", 0, 1);
    cyc("dhit",        0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, "EEEE", 0, 0);
    cyc("after_dw",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "EEEE", 0, 0);
    cyc("dstall2",     0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "SSSN", 0, 1);
    cyc("dhit_lu",     0, 1, 1, 1, 0, 0, 1, 1, 3, 3, 0, 0, "SNEE", 0, 0);
    cyc("lu_rt",       0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 5, 0, "SNEE", 0, 0);
    cyc("lu_r0",       0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, "EEEE", 0, 0);
    cyc("lu_rs",       0, 1, 0, 0, 0, 0, 1, 1, 7, 7, 2, 0, "SNEE", 0, 0);
    cyc("no_load",     0, 1, 0, 0, 0, 0, 0, 1, 5, 0, 5, 1, "EEEE", 0, 0);
    cyc("no_wb",       0, 1, 0, 0, 0, 0, 1, 0, 5, 5, 0, 1, "EEEE", 0, 0);
    cyc("imiss",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "NEEE", 0, 0);
    cyc("br_lu",       0, 1, 0, 0, 1, 0, 1, 1, 5, 0, 5, 1, "NNNE", 0, 0);
    cyc("after_br",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "EEEE", 0, 0);
    cyc("br_imiss",    0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "NNNE", 0, 0);
    cyc("ds_halt",     0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, "SSSN", 0, 1);
    cyc("halt_br",     0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, "NNNE", 0, 0);
    cyc("drain",       0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "NNNE", 0, 0);
    for (int i = 0; i < 12; i++)
      cyc("halted",    0, i[0], 0, i[1], i[2], i[3], 0, 0, 0, 0, 0, 0, "SSSS", 1, 0);
    cyc("rst_halted",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "NNNN", 0, 0);
    cyc("run_again",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "EEEE", 0, 0);
    cyc("dstall3",     0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "SSSN", 0, 1);
    cyc("rst_dwait",   1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "NNNN", 0, 0);
    cyc("post_rst",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "EEEE", 0, 0);
    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_queue: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_stage_controller.md
PIPELINE_STAGE_CONTROLLER -- requirements
Module: pipeline_stage_controller

Interface
REQ-001 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port ihit  input  1  instruction fetch complete this cycle.
REQ-004 SHALL have port dhit  input  1  data access in MEM complete this cycle.
REQ-005 SHALL have port dmem_req_mem  input  1  MEM-stage instruction reads or writes data memory.
REQ-006 SHALL have port branch_taken_mem  input  1  MEM stage redirects PC (taken branch or jump).
REQ-007 SHALL have port halt_mem  input  1  halt instruction in MEM.
REQ-008 SHALL have ports MemToReg_ex, RegWrite_ex  input  1 each  EX-stage load and writeback flags.
REQ-009 SHALL have ports regWSEL_ex, rs_id, rt_id  input  5 each  EX destination and ID source registers.
REQ-010 SHALL have port pc_en  output  1  PC register update enable.
REQ-011 SHALL have ports fd_state, de_state, em_state, mw_state  output  pipe_state_t each  per-register command: PIPE_ENABLE, PIPE_STALL or PIPE_NOP.
REQ-012 SHALL have ports halted, dwait  output  1 each  controller in HALTED or DWAIT state.
REQ-013 SHALL have ports stall_cycles, flush_count  output  32 each  performance counters.

Function
REQ-014 SHALL implement FSM states RUN, DWAIT, DRAIN, HALTED; stage commands combinational from state and inputs, no added latency.
REQ-015 SHALL define dstall = dmem_req_mem & !dhit and lu = MemToReg_ex & RegWrite_ex & (regWSEL_ex != 0) & (regWSEL_ex == rs_id | regWSEL_ex == rt_id).
REQ-016 In RUN/DWAIT, priority 1: dstall -> pc_en=0, fd/de/em=STALL, mw=NOP; next state DWAIT.
REQ-017 Priority 2: halt_mem -> pc_en=0, fd/de/em=NOP, mw=ENABLE; next state DRAIN.
REQ-018 Priority 3: branch_taken_mem -> pc_en=1, fd/de/em=NOP, mw=ENABLE; next state RUN.
REQ-019 Priority 4: lu -> pc_en=0, fd=STALL, de=NOP, em/mw=ENABLE; next state RUN.
REQ-020 Priority 5: !ihit -> pc_en=0, fd=NOP, de/em/mw=ENABLE; next state RUN.
REQ-021 Otherwise all four commands ENABLE, pc_en=1; next state RUN.
REQ-022 DWAIT with dhit=1 SHALL apply priorities 2-5/default that same cycle and return to RUN.
REQ-023 DRAIN SHALL last exactly one cycle: pc_en=0, fd/de/em=NOP, mw=ENABLE; next state HALTED.
REQ-024 HALTED: pc_en=0, all commands STALL, halted=1; exit only via RST.
REQ-025 lu with regWSEL_ex==0 SHALL not stall; simultaneous halt_mem and branch_taken_mem SHALL take the halt path.
REQ-026 stall_cycles SHALL increment each cycle pc_en=0 outside HALTED and reset; flush_count SHALL increment per cycle REQ-018 applies; both saturate at 32'hFFFF_FFFF.

Reset
REQ-027 While RST=1: pc_en=0, all commands PIPE_NOP, halted=0, dwait=0; state RUN and counters 0 after the edge.
REQ-028 RST asserted in any state, including DWAIT or HALTED, SHALL take effect on the next rising edge.

Configuration
REQ-029 Macro PIPE_PERF_CNT_EN defined: counters per REQ-026; undefined: counter logic absent, stall_cycles and flush_count tied to 0, ports retained.

Structure
REQ-030 pipe_state_t (PIPE_ENABLE, PIPE_STALL, PIPE_NOP) SHALL live in cpu_types_pkg; FSM state enum stays local to the module.
REQ-031 Load-use compare (REQ-015 lu) SHALL be sub-module load_use_detect, purely combinational.

Verification
REQ-032 Reset then ihit=1 constant, no hazards -> all ENABLE, pc_en=1 every cycle; stall_cycles=0.
REQ-033 dmem_req_mem=1, dhit=0 for 3 cycles then 1 -> 3 cycles fd/de/em=STALL, mw=NOP, dwait=1; 4th cycle all ENABLE; stall_cycles=3.
REQ-034 MemToReg_ex=1, RegWrite_ex=1, regWSEL_ex=5, rt_id=5 -> fd=STALL, de=NOP, pc_en=0 one cycle; with regWSEL_ex=0 -> no stall.
REQ-035 branch_taken_mem=1 with lu=1 -> pc_en=1, fd/de/em=NOP, mw=ENABLE; flush_count=1.
REQ-036 halt_mem=1 -> one DRAIN cycle (mw=ENABLE), then halted=1, all STALL for 10+ cycles; RST=1 -> RUN, halted=0.
REQ-037 Build without PIPE_PERF_CNT_EN, rerun REQ-033 -> stall_cycles=0, flush_count=0, stage commands unchanged.
